striping: RTL

STRIPING -- requirements
Module: striping

---
 rtl/striping.sv | 108 ++++++++++
 1 files changed

// File: rtl/striping.sv
// Two-lane word striper: accepted words alternate lane 0 / lane 1 with one cycle of latency.
// Optional accepted-word counter enabled by defining STRIPING_WCNT_EN.
module striping #(
  parameter int unsigned IDLE_RESYNC = 4
) (
  input  logic        clk_2f,
  input  logic        reset,
  input  logic [31:0] data_in,
  input  logic        valid_in,
  output logic [31:0] lane_0,
  output logic        valid_0,
  output logic [31:0] lane_1,
  output logic        valid_1
`ifdef STRIPING_WCNT_EN
  ,
  output logic [7:0]  word_count
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    STRIPE,
    HOLD
  } state_t;

  localparam logic [3:0] RESYNC = 4'(IDLE_RESYNC);

  state_t     state, state_nxt;
  logic       ptr, ptr_nxt;
  logic [3:0] idle_cnt, idle_cnt_nxt;
  logic       wr;
  logic       wr_lane;

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    idle_cnt_nxt = idle_cnt;
    wr           = 1'b0;
    wr_lane      = ptr;
    case (state)
      IDLE: begin
        wr_lane = 1'b0;
        if (valid_in) begin
          wr        = 1'b1;
          ptr_nxt   = 1'b1;
          state_nxt = STRIPE;
        end
      end
      STRIPE: begin
        if (valid_in) begin
          wr      = 1'b1;
          ptr_nxt = ~ptr;
        end else begin
          idle_cnt_nxt = 4'd1;
          state_nxt    = HOLD;
        end
      end
      HOLD: begin
        if (valid_in) begin
          wr           = 1'b1;
          ptr_nxt      = ~ptr;
          idle_cnt_nxt = '0;
          state_nxt    = STRIPE;
        end else if (idle_cnt >= RESYNC) begin
          // Long gap: realign so the next word starts on lane 0
          ptr_nxt      = 1'b0;
          idle_cnt_nxt = '0;
          state_nxt    = IDLE;
        end else begin
          idle_cnt_nxt = idle_cnt + 4'd1;
        end
      end
      default: begin
        ptr_nxt      = 1'b0;
        idle_cnt_nxt = '0;
        state_nxt    = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      state    <= IDLE;
      ptr      <= 1'b0;
      idle_cnt <= '0;
      lane_0   <= '0;
      lane_1   <= '0;
      valid_0  <= 1'b0;
      valid_1  <= 1'b0;
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      idle_cnt <= idle_cnt_nxt;
      valid_0  <= wr & ~wr_lane;
      valid_1  <= wr & wr_lane;
      if (wr && !wr_lane) lane_0 <= data_in;
      if (wr && wr_lane)  lane_1 <= data_in;
    end
  end

`ifdef STRIPING_WCNT_EN
  always_ff @(posedge clk_2f) begin
    if (reset)   word_count <= '0;
    else if (wr) word_count <= word_count + 8'd1;
  end
`endif

endmodule
